// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: streams a host image into the memory,
// verifies it by checksum readback, then hands the read port to CPU fetch.
module imem_load_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] exp_sum,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] pc_fetch_addr,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_dpra,
  input  logic [DATA_W-1:0] mem_dpo,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   stream_sum_q, stream_sum_d;
  logic [DATA_W-1:0]   rb_sum_q, rb_sum_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                s_ready_q, s_ready_d;
  logic                hs;

  assign hs = (state_q == ST_LOAD) && s_ready_q && s_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      exp_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      stream_sum_q <= '0;
      rb_sum_q     <= '0;
      words_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
      s_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      exp_q        <= exp_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stream_sum_q <= stream_sum_d;
      rb_sum_q     <= rb_sum_d;
      words_q      <= words_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      s_ready_q    <= s_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    exp_d        = exp_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    stream_sum_d = stream_sum_q;
    rb_sum_d     = rb_sum_q;
    words_d      = words_q;
    done_d       = done_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    s_ready_d    = s_ready_q;

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          len_d        = load_len;
          exp_d        = exp_sum;
          done_d       = 1'b0;
          err_d        = 1'b0;
          err_code_d   = 2'b00;
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          stream_sum_d = '0;
          rb_sum_d     = '0;
          words_d      = '0;
          if ((load_len == '0) || (load_len > DEPTH_L)) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = 2'b11;
            s_ready_d  = 1'b0;
          end else begin
            state_d   = ST_LOAD;
            s_ready_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (hs) begin
          wr_ptr_d     = wr_ptr_q + 1'b1;
          stream_sum_d = stream_sum_q + s_data;
          words_d      = words_q + 1'b1;
          if (words_q == len_q - 1'b1) begin
            state_d   = ST_VERIFY;
            s_ready_d = 1'b0;
          end
        end
      end
      ST_VERIFY: begin
        // rd_ptr reaching len means all len words have been summed; compare now
        if (rd_ptr_q == len_q) begin
          if (stream_sum_q != exp_q) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (rb_sum_q != stream_sum_q) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end else begin
          rb_sum_d = rb_sum_q + mem_dpo;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_a    = '0;
    mem_d    = '0;
    mem_we   = 1'b0;
    mem_dpra = '0;
    instr    = '0;
    cpu_run  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        mem_a  = wr_ptr_q[ADDR_W-1:0];
        mem_d  = s_data;
        mem_we = hs;
        busy   = 1'b1;
      end
      ST_VERIFY: begin
        mem_dpra = rd_ptr_q[ADDR_W-1:0];
        busy     = 1'b1;
      end
      ST_RUN: begin
        mem_dpra = pc_fetch_addr;
        instr    = mem_dpo;
        cpu_run  = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_ready      = s_ready_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl with a behavioural memory and
// an outcome model derived from the load/verify rules.
module tb_imem_load_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [DATA_W-1:0] exp_sum = '0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready;
  logic [ADDR_W-1:0] pc_fetch_addr = '0;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_dpra;
  logic [DATA_W-1:0] mem_dpo;
  logic [DATA_W-1:0] instr;
  logic              cpu_run;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] memArr [0:DEPTH-1];
  logic [DATA_W-1:0] stimData [0:DEPTH-1];
  logic [ADDR_W-1:0] wrAddrQ [$];
  logic [DATA_W-1:0] wrDataQ [$];
  bit                corruptAddr5 = 1'b0;

  imem_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .exp_sum(exp_sum), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .pc_fetch_addr(pc_fetch_addr), .mem_a(mem_a), .mem_d(mem_d),
    .mem_we(mem_we), .mem_dpra(mem_dpra), .mem_dpo(mem_dpo), .instr(instr),
    .cpu_run(cpu_run), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Distributed RAM model: synchronous write, asynchronous read, optional fault at word 5
  assign mem_dpo = memArr[mem_dpra] ^ ((corruptAddr5 && (mem_dpra == 10'd5)) ? 32'h1 : 32'h0);

  always @(posedge clk) begin
    if (mem_we) begin
      memArr[mem_a] <= mem_d;
      wrAddrQ.push_back(mem_a);
      wrDataQ.push_back(mem_d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One complete load; bubbleMode 0 = none, 1 = alternating, 2 = random
  task automatic applyStimulus(input int n, input logic [31:0] expS, input int bubbleMode,
                               input bit corrupt, input bit pokeStart);
    int base;
    int c;
    int idx;
    int lastLoad;
    int badCnt;
    int fetchAddr;
    bit v;
    bit bad;
    logic [31:0] sum;
    logic [1:0] expCode;
    base = wrAddrQ.size();
    corruptAddr5 = corrupt;
    bad = (n == 0) || (n > DEPTH);

    start = 1'b1;
    load_len = (ADDR_W+1)'(n);
    exp_sum = expS;
    s_valid = 1'b0;
    tick();
    start = 1'b0;
    c = 0;
    checkOutput("cpu_run_after_start", cpu_run, 0);

    if (bad) begin
      checkOutput("badlen_err", err, 1);
      checkOutput("badlen_code", err_code, 2'b11);
      checkOutput("badlen_busy", busy, 0);
      checkOutput("badlen_done", done, 0);
      checkOutput("badlen_words", words_loaded, 0);
      tick();
      tick();
      checkOutput("badlen_no_writes", wrAddrQ.size(), base);
      return;
    end

    checkOutput("load_s_ready", s_ready, 1);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_done_cleared", {done, err, err_code}, 0);

    idx = 0;
    while (idx < n && c < 4 * n + 100) begin
      case (bubbleMode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s_valid = v;
      s_data = v ? stimData[idx] : $urandom;
      if (pokeStart && idx == n / 2) begin
        start = 1'b1;
        load_len = '0;
      end
      tick();
      start = 1'b0;
      c++;
      if (v) idx++;
    end
    s_valid = 1'b0;
    checkOutput("load_handshakes_done", idx, n);
    lastLoad = c;
    checkOutput("verify_s_ready_low", s_ready, 0);
    checkOutput("verify_busy", busy, 1);
    checkOutput("words_loaded", words_loaded, n);

    while (!(cpu_run || err) && c < lastLoad + n + 10) begin
      tick();
      c++;
    end
    checkOutput("finish_cycle", c, lastLoad + n + 1);

    sum = 32'h0;
    for (int i = 0; i < n; i++) sum = sum + stimData[i];
    if (sum != expS) expCode = 2'b01;
    else if (corrupt && n > 5) expCode = 2'b10;
    else expCode = 2'b00;

    checkOutput("final_done", done, expCode == 2'b00);
    checkOutput("final_err", err, expCode != 2'b00);
    checkOutput("final_err_code", err_code, expCode);
    checkOutput("final_cpu_run", cpu_run, expCode == 2'b00);
    checkOutput("final_busy", busy, 0);
    checkOutput("final_words_loaded", words_loaded, n);

    checkOutput("write_count", wrAddrQ.size() - base, n);
    badCnt = 0;
    if (wrAddrQ.size() >= base + n) begin
      for (int i = 0; i < n; i++) begin
        if (wrAddrQ[base + i] !== 10'(i) || wrDataQ[base + i] !== stimData[i]) badCnt++;
      end
    end
    checkOutput("write_addr_data", badCnt, 0);

    if (expCode == 2'b00) begin
      fetchAddr = $urandom_range(0, n - 1);
      pc_fetch_addr = 10'(fetchAddr);
      #1;
      checkOutput("run_fetch_instr", instr, stimData[fetchAddr]);
    end else begin
      checkOutput("error_instr_nop", instr, 0);
    end
  endtask

  initial begin
    logic [31:0] s;
    int n;
    $display("[TB] start");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_flags", {s_ready, mem_we, cpu_run, busy, done, err}, 0);
    checkOutput("reset_err_code", err_code, 0);
    checkOutput("reset_words", words_loaded, 0);
    checkOutput("reset_mem_ports", {mem_a, mem_d, mem_dpra}, 0);
    checkOutput("reset_instr", instr, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) stimData[i] = 32'(i + 1);
    applyStimulus(4, 32'h0000000A, 0, 1'b0, 1'b0);
    applyStimulus(4, 32'h0000000B, 0, 1'b0, 1'b0);

    applyStimulus(0, 32'h0, 0, 1'b0, 1'b0);
    applyStimulus(1025, 32'h0, 0, 1'b0, 1'b0);
    applyStimulus(2047, 32'h0, 0, 1'b0, 1'b0);

    stimData[0] = 32'hA;
    stimData[1] = 32'hB;
    stimData[2] = 32'hC;
    applyStimulus(3, 32'h21, 1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a load
    start = 1'b1;
    load_len = 11'd8;
    exp_sum = 32'h0;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h55;
    tick();
    tick();
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_s_ready", s_ready, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_mem_we", mem_we, 0);
    checkOutput("midreset_words", words_loaded, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    stimData[0] = 32'h1234_5678;
    stimData[1] = 32'h9ABC_DEF0;
    applyStimulus(2, 32'h1234_5678 + 32'h9ABC_DEF0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 40);
      s = 32'h0;
      for (int i = 0; i < n; i++) begin
        stimData[i] = $urandom;
        s = s + stimData[i];
      end
      if ($urandom_range(0, 1) == 1) s = s ^ (32'h1 << $urandom_range(0, 31));
      applyStimulus(n, s, t % 3, (t == 4), (t == 2));
    end

    for (int i = 0; i < DEPTH; i++) stimData[i] = 32'hFFFF_FFFF;
    applyStimulus(DEPTH, 32'hFFFF_FC00, 0, 1'b0, 1'b0);
    pc_fetch_addr = 10'd3;
    #1;
    checkOutput("full_fetch_addr3", instr, 32'hFFFF_FFFF);
    checkOutput("full_fetch_dpra", mem_dpra, 10'd3);

    applyStimulus(DEPTH, 32'hFFFF_FC00, 0, 1'b1, 1'b0);
    corruptAddr5 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
